// File: rtl/tlb_op_sequencer_if.sv
// Bundle of the WB request handshake and the TLB read/search/write ports
// shared between the TLB maintenance sequencer and its surroundings.
interface tlb_op_sequencer_if #(
  parameter int IDXW = 4
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [4:0]      req_invop;
  logic [9:0]      req_asid;
  logic [18:0]     req_vppn;
  logic [IDXW-1:0] req_index;
  logic [18:0]     s1_vppn;
  logic [9:0]      s1_asid;
  logic            s1_found;
  logic [IDXW-1:0] s1_index;
  logic [IDXW-1:0] r_index;
  logic            r_e;
  logic            r_g;
  logic [5:0]      r_ps;
  logic [9:0]      r_asid;
  logic [18:0]     r_vppn;
  logic            we;
  logic [IDXW-1:0] w_index;
  logic            w_clear;
  logic            csr_srch_we;
  logic            srch_found;
  logic [IDXW-1:0] srch_index;
  logic            csr_rd_we;
  logic            done;

  modport slave (
    input  req_valid, req_op, req_invop, req_asid, req_vppn, req_index,
    input  s1_found, s1_index, r_e, r_g, r_ps, r_asid, r_vppn,
    output req_ready, s1_vppn, s1_asid, r_index, we, w_index, w_clear,
    output csr_srch_we, srch_found, srch_index, csr_rd_we, done
  );

  modport master (
    output req_valid, req_op, req_invop, req_asid, req_vppn, req_index,
    output s1_found, s1_index, r_e, r_g, r_ps, r_asid, r_vppn,
    input  req_ready, s1_vppn, s1_asid, r_index, we, w_index, w_clear,
    input  csr_srch_we, srch_found, srch_index, csr_rd_we, done
  );
endinterface

// File: rtl/tlb_op_sequencer.sv
// Sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB against the TLB ports, keeps the
// FILL replacement pointer and scans all entries for INVTLB one per cycle.
module tlb_op_sequencer #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input logic            clk,
  input logic            resetn,
  tlb_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SRCH = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_FILL = 3'd4,
    ST_INV  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);

  state_t          state_r;
  logic [4:0]      invop_r;
  logic [9:0]      asid_r;
  logic [18:0]     vppn_r;
  logic [IDXW-1:0] index_r;
  logic [IDXW-1:0] fill_ptr_r;
  logic [IDXW-1:0] inv_cnt_r;
  logic            srch_found_r;
  logic [IDXW-1:0] srch_index_r;
  logic            ready_r;
  logic            done_r;
  logic            srch_we_r;
  logic            rd_we_r;
  logic            wr_we_r;
  logic [IDXW-1:0] wr_index_r;

  logic            asid_eq_s;
  logic            va_eq_s;
  logic            inv_we_s;

  // INVTLB op-field selection of which valid entries are invalidated
  function automatic logic inv_sel(input logic [4:0] invop, input logic g,
                                   input logic asid_eq, input logic va_eq);
    logic sel;
    case (invop)
      5'd0, 5'd1: sel = 1'b1;
      5'd2:       sel = g;
      5'd3:       sel = ~g;
      5'd4:       sel = ~g & asid_eq;
      5'd5:       sel = ~g & asid_eq & va_eq;
      5'd6:       sel = (g | asid_eq) & va_eq;
      default:    sel = 1'b0;
    endcase
    return sel;
  endfunction

  // Match of the entry currently presented on the read port during the scan
  always_comb begin
    asid_eq_s = (bus.r_asid == asid_r);
    if (bus.r_ps == 6'd21) begin
      va_eq_s = (bus.r_vppn[18:9] == vppn_r[18:9]);
    end else begin
      va_eq_s = (bus.r_vppn == vppn_r);
    end
    if (state_r == ST_INV) begin
      inv_we_s = bus.r_e & inv_sel(invop_r, bus.r_g, asid_eq_s, va_eq_s);
    end else begin
      inv_we_s = 1'b0;
    end
  end

  assign bus.req_ready   = ready_r;
  assign bus.s1_vppn     = vppn_r;
  assign bus.s1_asid     = asid_r;
  assign bus.r_index     = (state_r == ST_INV) ? inv_cnt_r : index_r;
  assign bus.we          = wr_we_r | inv_we_s;
  assign bus.w_index     = inv_we_s ? inv_cnt_r : wr_index_r;
  assign bus.w_clear     = inv_we_s;
  assign bus.csr_srch_we = srch_we_r;
  assign bus.srch_found  = srch_found_r;
  assign bus.srch_index  = srch_index_r;
  assign bus.csr_rd_we   = rd_we_r;
  assign bus.done        = done_r;

  // Operation FSM; strobes are set on entry to the state they belong to
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      invop_r      <= 5'd0;
      asid_r       <= 10'd0;
      vppn_r       <= 19'd0;
      index_r      <= IDX_ZERO;
      fill_ptr_r   <= IDX_ZERO;
      inv_cnt_r    <= IDX_ZERO;
      srch_found_r <= 1'b0;
      srch_index_r <= IDX_ZERO;
      ready_r      <= 1'b1;
      done_r       <= 1'b0;
      srch_we_r    <= 1'b0;
      rd_we_r      <= 1'b0;
      wr_we_r      <= 1'b0;
      wr_index_r   <= IDX_ZERO;
    end else begin
      done_r    <= 1'b0;
      srch_we_r <= 1'b0;
      rd_we_r   <= 1'b0;
      wr_we_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            ready_r <= 1'b0;
            invop_r <= bus.req_invop;
            asid_r  <= bus.req_asid;
            vppn_r  <= bus.req_vppn;
            index_r <= bus.req_index;
            case (bus.req_op)
              3'd0: state_r <= ST_SRCH;
              3'd1: begin
                state_r <= ST_RD;
                rd_we_r <= 1'b1;
              end
              3'd2: begin
                state_r    <= ST_WR;
                wr_we_r    <= 1'b1;
                wr_index_r <= bus.req_index;
              end
              3'd3: begin
                state_r    <= ST_FILL;
                wr_we_r    <= 1'b1;
                wr_index_r <= fill_ptr_r;
              end
              3'd4: begin
                state_r   <= ST_INV;
                inv_cnt_r <= IDX_ZERO;
              end
              default: begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end
            endcase
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_SRCH: begin
          srch_found_r <= bus.s1_found;
          srch_index_r <= bus.s1_index;
          srch_we_r    <= 1'b1;
          done_r       <= 1'b1;
          state_r      <= ST_DONE;
        end
        ST_RD, ST_WR: begin
          done_r  <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_FILL: begin
          // TLBNUM is a power of two, so the natural wrap gives LAST_IDX -> 0
          fill_ptr_r <= fill_ptr_r + IDX_ONE;
          done_r     <= 1'b1;
          state_r    <= ST_DONE;
        end
        ST_INV: begin
          if (inv_cnt_r == LAST_IDX) begin
            inv_cnt_r <= IDX_ZERO;
            done_r    <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            inv_cnt_r <= inv_cnt_r + IDX_ONE;
          end
        end
        ST_DONE: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed self-checking bench for tlb_op_sequencer with a small TLB entry model
// driving the read/search ports.
module tb_tlb_op_sequencer;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   acc_cyc;
  int   lat;
  int   wr_k[$];
  int   wr_idx[$];
  int   wr_clr[$];
  int   srch_n, srch_k, rd_n, rd_k, rd_idx, rdy_n;

  logic        m_e[16];
  logic        m_g[16];
  logic [5:0]  m_ps[16];
  logic [9:0]  m_asid[16];
  logic [18:0] m_vppn[16];
  logic        hit_en;
  logic [3:0]  hit_idx;

  tlb_op_sequencer_if #(.IDXW(4)) bus();

  tlb_op_sequencer #(.TLBNUM(16), .IDXW(4)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  assign bus.s1_found = hit_en;
  assign bus.s1_index = hit_idx;
  assign bus.r_e      = m_e[bus.r_index];
  assign bus.r_g      = m_g[bus.r_index];
  assign bus.r_ps     = m_ps[bus.r_index];
  assign bus.r_asid   = m_asid[bus.r_index];
  assign bus.r_vppn   = m_vppn[bus.r_index];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_entry(input int i, input logic e, input logic g, input logic [5:0] ps,
                           input logic [9:0] asid, input logic [18:0] vppn);
    m_e[i] = e; m_g[i] = g; m_ps[i] = ps; m_asid[i] = asid; m_vppn[i] = vppn;
  endtask

  task automatic to_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [4:0] invop, input logic [9:0] asid,
                          input logic [18:0] vppn, input logic [3:0] idx, input bit hold);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_idle op%0d: got %b expected 1", op, bus.req_ready);
    end
    bus.req_op = op; bus.req_invop = invop; bus.req_asid = asid;
    bus.req_vppn = vppn; bus.req_index = idx; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    lat = -1;
    wr_k.delete(); wr_idx.delete(); wr_clr.delete();
    srch_n = 0; srch_k = 0; rd_n = 0; rd_k = 0; rd_idx = -1; rdy_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      k = cyc - acc_cyc + 1;
      if (bus.we) begin
        wr_k.push_back(k); wr_idx.push_back(int'(bus.w_index)); wr_clr.push_back(int'(bus.w_clear));
      end
      if (bus.csr_srch_we) begin srch_n++; srch_k = k; end
      if (bus.csr_rd_we) begin rd_n++; rd_k = k; rd_idx = int'(bus.r_index); end
      if (bus.req_ready) rdy_n++;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_we", int'(bus.we), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_csr", int'({bus.csr_srch_we, bus.csr_rd_we, bus.w_clear}), 0);
    resetn = 1'b1;
    to_idle();
    chk("rst_ready", int'(bus.req_ready), 1);
    chk("rst_srch_found", int'(bus.srch_found), 0);
    chk("rst_srch_index", int'(bus.srch_index), 0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 17; i++) begin
      start_op(3'd3, 5'd0, 10'd0, 19'd0, 4'd15, 1'b1);
      wait_done();
      chk($sformatf("fill%0d_lat", i), lat, 2);
      chk($sformatf("fill%0d_ready", i), rdy_n, 0);
      chk($sformatf("fill%0d_nwr", i), wr_k.size(), 1);
      if (wr_k.size() == 1) begin
        chk($sformatf("fill%0d_idx", i), wr_idx[0], i % 16);
        chk($sformatf("fill%0d_clr", i), wr_clr[0], 0);
        chk($sformatf("fill%0d_k", i), wr_k[0], 1);
      end
      to_idle();
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_srch();
    hit_en = 1'b1; hit_idx = 4'd9;
    start_op(3'd0, 5'd0, 10'd5, 19'h12345, 4'd0, 1'b0);
    wait_done();
    chk("srch_lat", lat, 2);
    chk("srch_found", int'(bus.srch_found), 1);
    chk("srch_index", int'(bus.srch_index), 9);
    chk("srch_we_n", srch_n, 1);
    chk("srch_we_k", srch_k, 2);
    chk("srch_nwr", wr_k.size(), 0);
    chk("srch_s1_vppn", int'(bus.s1_vppn), 32'h12345);
    chk("srch_s1_asid", int'(bus.s1_asid), 5);
    to_idle();
    hit_en = 1'b0; hit_idx = 4'd3;
    start_op(3'd0, 5'd0, 10'd6, 19'h00001, 4'd0, 1'b0);
    wait_done();
    chk("miss_found", int'(bus.srch_found), 0);
    chk("miss_we_n", srch_n, 1);
    to_idle();
  endtask

  task automatic test_rd_wr();
    start_op(3'd1, 5'd0, 10'd0, 19'd0, 4'd7, 1'b0);
    wait_done();
    chk("rd_lat", lat, 2);
    chk("rd_we_n", rd_n, 1);
    chk("rd_we_k", rd_k, 1);
    chk("rd_index", rd_idx, 7);
    chk("rd_nwr", wr_k.size(), 0);
    to_idle();
    start_op(3'd2, 5'd0, 10'd0, 19'd0, 4'd11, 1'b0);
    wait_done();
    chk("wr_lat", lat, 2);
    chk("wr_nwr", wr_k.size(), 1);
    if (wr_k.size() == 1) begin
      chk("wr_idx", wr_idx[0], 11);
      chk("wr_clr", wr_clr[0], 0);
      chk("wr_k", wr_k[0], 1);
    end
    to_idle();
  endtask

  task automatic test_inv();
    int exp_all[5];
    exp_all = '{2, 5, 6, 8, 9};
    start_op(3'd4, 5'd5, 10'd3, 19'h00400, 4'd0, 1'b0);
    wait_done();
    chk("inv5_lat", lat, 17);
    chk("inv5_nwr", wr_k.size(), 2);
    if (wr_k.size() == 2) begin
      chk("inv5_idx0", wr_idx[0], 2);
      chk("inv5_k0", wr_k[0], 3);
      chk("inv5_clr0", wr_clr[0], 1);
      chk("inv5_idx1", wr_idx[1], 8);
      chk("inv5_k1", wr_k[1], 9);
      chk("inv5_clr1", wr_clr[1], 1);
    end
    to_idle();
    start_op(3'd4, 5'd0, 10'd0, 19'd0, 4'd0, 1'b0);
    wait_done();
    chk("inv0_nwr", wr_k.size(), 5);
    if (wr_k.size() == 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("inv0_idx%0d", i), wr_idx[i], exp_all[i]);
    end
    to_idle();
    start_op(3'd4, 5'd9, 10'd3, 19'h00400, 4'd0, 1'b0);
    wait_done();
    chk("inv9_lat", lat, 17);
    chk("inv9_nwr", wr_k.size(), 0);
    to_idle();
  endtask

  task automatic test_reserved();
    start_op(3'd6, 5'd0, 10'd1, 19'd1, 4'd1, 1'b0);
    wait_done();
    chk("rsv_lat", lat, 1);
    chk("rsv_nwr", wr_k.size(), 0);
    chk("rsv_strobes", srch_n + rd_n, 0);
    to_idle();
    start_op(3'd3, 5'd0, 10'd0, 19'd0, 4'd0, 1'b0);
    wait_done();
    chk("rsv_fill_nwr", wr_k.size(), 1);
    if (wr_k.size() == 1) chk("rsv_fill_idx", wr_idx[0], 1);
    to_idle();
  endtask

  task automatic test_reset_mid_inv();
    int k;
    start_op(3'd4, 5'd0, 10'd0, 19'd0, 4'd0, 1'b0);
    k = 0;
    for (int c = 0; c < 20 && k != 7; c++) begin
      @(negedge clk);
      k = cyc - acc_cyc + 1;
    end
    chk("mid_pre_we", int'(bus.we), 1);
    chk("mid_pre_idx", int'(bus.w_index), 6);
    resetn = 1'b0;
    #1;
    chk("mid_rst_we", int'(bus.we), 0);
    chk("mid_rst_clr", int'(bus.w_clear), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    @(negedge clk);
    resetn = 1'b1;
    to_idle();
    chk("mid_ready", int'(bus.req_ready), 1);
    start_op(3'd3, 5'd0, 10'd0, 19'd0, 4'd0, 1'b0);
    wait_done();
    chk("mid_fill_lat", lat, 2);
    chk("mid_fill_nwr", wr_k.size(), 1);
    if (wr_k.size() == 1) chk("mid_fill_idx", wr_idx[0], 0);
    to_idle();
  endtask

  initial begin
    resetn = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_invop = 5'd0;
    bus.req_asid = 10'd0; bus.req_vppn = 19'd0; bus.req_index = 4'd0;
    hit_en = 1'b0; hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) set_entry(i, 1'b0, 1'b0, 6'd12, 10'd0, 19'd0);
    set_entry(2,  1'b1, 1'b0, 6'd12, 10'd3, 19'h00400);
    set_entry(5,  1'b1, 1'b1, 6'd12, 10'd0, 19'h00400);
    set_entry(6,  1'b1, 1'b1, 6'd12, 10'd7, 19'h7FFFF);
    set_entry(8,  1'b1, 1'b0, 6'd21, 10'd3, 19'h005FF);
    set_entry(9,  1'b1, 1'b0, 6'd12, 10'd4, 19'h00400);
    set_entry(11, 1'b0, 1'b0, 6'd12, 10'd3, 19'h00400);
    test_reset();
    test_fill();
    test_srch();
    test_rd_wr();
    test_inv();
    test_reserved();
    test_reset_mid_inv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
